imem_loader: RTL

Boot-time program loader that fills the CPU's instruction memory. It accepts a byte stream on a valid/ready handshake, assembles the bytes into 32-bit little-endian instruction words, and writes them to sequential instruction-memory addresses from 0. While a load is in progress it holds the CPU in reset-like stall via `cpu_hold`, so fetch never sees a half-written program.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the program-loader state encoding.
// Used by imem_loader and byte_packer.
package cpu_pkg;

  localparam int INST_W        = 32;
  localparam int LDR_HDR_BYTES = 2;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CSUM
  } ldr_state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles a little-endian byte stream into instruction words; the completed
// word is presented combinationally in the cycle its fourth byte is accepted.
module byte_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic [INST_W-1:0] word,
  output logic              word_done
);

  logic [1:0]          lane_q;
  logic [INST_W-9:0]   low_q;

  assign word      = {in_data, low_q};
  assign word_done = in_valid && (lane_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= 2'd0;
      low_q  <= '0;
    end else if (clear) begin
      lane_q <= 2'd0;
      low_q  <= '0;
    end else if (in_valid) begin
      lane_q <= lane_q + 2'd1;
      case (lane_q)
        2'd0:    low_q[7:0]   <= in_data;
        2'd1:    low_q[15:8]  <= in_data;
        2'd2:    low_q[23:16] <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: header, payload words, optional trailer.
// Optional XOR checksum trailer enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [INST_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int HDR_IDX_W = $clog2(LDR_HDR_BYTES);

  ldr_state_e           state_q, state_d;
  logic [HDR_IDX_W-1:0] hdr_idx_q;
  logic [7:0]           n_lo_q;
  logic [15:0]          words_left_q;
  logic [ADDR_W-1:0]    addr_q;

  logic                 accept, hdr_last, hdr_too_big, begin_load;
  logic [15:0]          hdr_n;
  logic                 pk_valid, pk_done;
  logic [INST_W-1:0]    pk_word;
  logic                 write, finish, fail;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [INST_W-1:0]    csum_q;
`endif

  assign s_ready     = (state_q != IDLE);
  assign cpu_hold    = (state_q != IDLE);
  assign accept      = s_valid && s_ready;
  assign begin_load  = (state_q == IDLE) && start;
  assign hdr_last    = (hdr_idx_q == HDR_IDX_W'(LDR_HDR_BYTES - 1));
  assign hdr_n       = {s_data, n_lo_q};
  // N may equal the full address space but never exceed it
  assign hdr_too_big = ({16'd0, hdr_n} > (32'd1 << ADDR_W));
  assign pk_valid    = accept && ((state_q == PAYLOAD) || (state_q == CSUM));

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (begin_load),
    .in_valid  (pk_valid),
    .in_data   (s_data),
    .word      (pk_word),
    .word_done (pk_done)
  );

  always_comb begin
    state_d = state_q;
    write   = 1'b0;
    finish  = 1'b0;
    fail    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        if (accept && hdr_last) begin
          if (hdr_too_big) begin
            fail    = 1'b1;
            finish  = 1'b1;
            state_d = IDLE;
          end else if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            finish  = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (pk_done) begin
          write = 1'b1;
          if (words_left_q == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            finish  = 1'b1;
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (pk_done) begin
          finish  = 1'b1;
          fail    = (pk_word != csum_q);
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hdr_idx_q    <= '0;
      n_lo_q       <= 8'd0;
      words_left_q <= 16'd0;
      addr_q       <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en   <= write;
      done    <= finish;
      if (begin_load) begin
        error     <= 1'b0;
        hdr_idx_q <= '0;
        addr_q    <= '0;
      end else if (fail) begin
        error <= 1'b1;
      end
      if ((state_q == HDR) && accept) begin
        hdr_idx_q <= hdr_idx_q + HDR_IDX_W'(1);
        if (hdr_last) words_left_q <= hdr_n;
        else          n_lo_q       <= s_data;
      end
      if (write) begin
        wr_addr      <= addr_q;
        wr_data      <= pk_word;
        addr_q       <= addr_q + ADDR_W'(1);
        words_left_q <= words_left_q - 16'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of every payload word, matched against the trailer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          csum_q <= '0;
    else if (begin_load) csum_q <= '0;
    else if (write)      csum_q <= csum_q ^ pk_word;
  end
`endif

endmodule
